// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared MLP sequencer types and constants
package mlp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_RELU  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEFAULT_IN_WIDTH = 16;
    localparam int Q8_8_ONE         = 256;

endpackage

// File: rtl/mlp_hidden_sequencer.sv
// rtl/mlp_hidden_sequencer.sv - feeds bias plus features serially to the hidden layer
// Optional output handshake: MLP_SEQ_OUT_BACKPRESSURE_EN
module mlp_hidden_sequencer
    import mlp_pkg::*;
#(
    parameter  int N_FEATURES = 2,
    parameter  int IN_WIDTH   = DEFAULT_IN_WIDTH,
    parameter  int BIAS_VAL   = Q8_8_ONE,
    localparam int N_INPUTS   = N_FEATURES + 1,
    localparam int IDX_W      = $clog2(N_INPUTS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_FEATURES*IN_WIDTH-1:0] in_features_flat,
    input  logic                           wr_en_mon,
`ifdef MLP_SEQ_OUT_BACKPRESSURE_EN
    input  logic                           out_ready,
`endif
    output logic [IDX_W-1:0]               input_index,
    output logic signed [IN_WIDTH-1:0]     input_value,
    output logic                           start,
    output logic                           valid,
    output logic                           relu_en,
    output logic                           out_valid,
    output logic                           busy,
    output logic                           load_collision
);

    localparam logic signed [IN_WIDTH-1:0] BIAS_W   = IN_WIDTH'(BIAS_VAL);
    localparam logic [IDX_W-1:0]           LAST_IDX = IDX_W'(N_INPUTS - 1);

    state_t                          state;
    state_t                          state_nxt;
    logic [IDX_W-1:0]                cnt;
    logic [N_FEATURES*IN_WIDTH-1:0]  feat_q;
    logic signed [IN_WIDTH-1:0]      cur_elem;
    logic                            accept;

    assign accept = in_valid && in_ready;

    // Element selected by the index being issued this cycle; the layer sees it one cycle later.
    always_comb begin
        cur_elem = BIAS_W;
        for (int k = 0; k < N_FEATURES; k++) begin
            if (cnt == IDX_W'(k + 1)) begin
                cur_elem = feat_q[k*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        input_index = '0;
        relu_en     = 1'b0;
        out_valid   = 1'b0;
        case (state)
            ST_IDLE: begin
                busy     = 1'b0;
                in_ready = !wr_en_mon;
                if (in_valid && !wr_en_mon) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                input_index = cnt;
                if (cnt == LAST_IDX) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_nxt = ST_RELU;
            end
            ST_RELU: begin
                relu_en   = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
`ifdef MLP_SEQ_OUT_BACKPRESSURE_EN
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
`else
                state_nxt = ST_IDLE;
`endif
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            feat_q         <= '0;
            input_value    <= '0;
            start          <= 1'b0;
            valid          <= 1'b0;
            load_collision <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                feat_q <= in_features_flat;
            end
            cnt   <= (state == ST_ISSUE) ? cnt + 1'b1 : '0;
            start <= (state == ST_ISSUE) && (cnt == '0);
            valid <= (state == ST_ISSUE) && (cnt != '0);
            // Value holds between transactions so the MAC inputs stay quiet.
            if (state == ST_ISSUE) begin
                input_value <= cur_elem;
            end
            if ((state != ST_IDLE) && wr_en_mon) begin
                load_collision <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mlp_hidden_sequencer.sv
// tb/tb_mlp_hidden_sequencer.sv - scoreboard bench for mlp_hidden_sequencer
module tb_mlp_hidden_sequencer;

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] val;
        logic        st;
        logic        vl;
        logic        re;
        logic        ov;
        logic        rdy;
        logic        bsy;
        logic        lc;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_features_flat = '0;
    logic        wr_en_mon = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  input_index;
    logic signed [15:0] input_value;
    logic        start;
    logic        valid;
    logic        relu_en;
    logic        out_valid;
    logic        busy;
    logic        load_collision;

    int          n_checks = 0;
    int          n_fail = 0;
    obs_t        exp_q[$];
    logic [15:0] exp_hold = '0;
    obs_t        obs;
    obs_t        expv;

    always #5 clk = ~clk;

    mlp_hidden_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_features_flat (in_features_flat),
        .wr_en_mon        (wr_en_mon),
`ifdef MLP_SEQ_OUT_BACKPRESSURE_EN
        .out_ready        (out_ready),
`endif
        .input_index      (input_index),
        .input_value      (input_value),
        .start            (start),
        .valid            (valid),
        .relu_en          (relu_en),
        .out_valid        (out_valid),
        .busy             (busy),
        .load_collision   (load_collision)
    );

    function automatic obs_t sample();
        obs_t o;
        o.idx = input_index;
        o.val = input_value;
        o.st  = start;
        o.vl  = valid;
        o.re  = relu_en;
        o.ov  = out_valid;
        o.rdy = in_ready;
        o.bsy = busy;
        o.lc  = load_collision;
        return o;
    endfunction

    function automatic void push_idle(input logic rdy, input logic lc);
        obs_t o;
        o = '0;
        o.val = exp_hold;
        o.rdy = rdy;
        o.lc  = lc;
        exp_q.push_back(o);
    endfunction

    // Expected trace for cycles 1..kmax after acceptance (cycle 0).
    function automatic void push_txn(input logic [15:0] f0, input logic [15:0] f1,
                                     input int kmax, input int lc_from);
        logic [15:0] e [3];
        obs_t o;
        e[0] = 16'h0100;
        e[1] = f0;
        e[2] = f1;
        for (int k = 1; k <= kmax; k++) begin
            o = '0;
            o.idx = (k <= 3) ? 2'(k - 1) : 2'd0;
            if (k >= 2 && k <= 4) exp_hold = e[k-2];
            o.val = exp_hold;
            o.st  = (k == 2);
            o.vl  = (k == 3) || (k == 4);
            o.re  = (k == 5);
            o.ov  = (k == 6);
            o.rdy = 1'b0;
            o.bsy = 1'b1;
            o.lc  = (k >= lc_from);
            exp_q.push_back(o);
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_hold = '0;
        push_idle(1'b1, 1'b0);
        push_idle(1'b1, 1'b0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            @(negedge clk);
            obs = sample();
            expv = exp_q.pop_front();
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got %h want %h", c, obs, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single();
        push_idle(1'b1, 1'b0);
        push_txn(16'h0100, 16'hFF00, 6, 100);
        push_idle(1'b1, 1'b0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            if (c == 0) begin
                in_valid = 1'b1;
                in_features_flat = {16'hFF00, 16'h0100};
            end
            if (c == 1) in_valid = 1'b0;
            @(negedge clk);
            obs = sample();
            expv = exp_q.pop_front();
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL single cyc%0d: got %h want %h", c, obs, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        push_idle(1'b1, 1'b0);
        push_txn(16'h0010, 16'h0020, 6, 100);
        push_idle(1'b1, 1'b0);
        push_txn(16'h7FFF, 16'h8000, 6, 100);
        push_idle(1'b1, 1'b0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            if (c == 0) begin
                in_valid = 1'b1;
                in_features_flat = {16'h0020, 16'h0010};
            end
            if (c == 3) in_features_flat = {16'h8000, 16'h7FFF};
            if (c == 8) in_valid = 1'b0;
            @(negedge clk);
            obs = sample();
            expv = exp_q.pop_front();
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL back_to_back cyc%0d: got %h want %h", c, obs, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wr_en_idle();
        push_idle(1'b0, 1'b0);
        push_idle(1'b0, 1'b0);
        push_idle(1'b1, 1'b0);
        push_txn(16'h0003, 16'hFFFD, 6, 100);
        push_idle(1'b1, 1'b0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            if (c == 0) begin
                in_valid = 1'b1;
                wr_en_mon = 1'b1;
                in_features_flat = {16'hFFFD, 16'h0003};
            end
            if (c == 2) wr_en_mon = 1'b0;
            if (c == 3) in_valid = 1'b0;
            @(negedge clk);
            obs = sample();
            expv = exp_q.pop_front();
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL wr_en_idle cyc%0d: got %h want %h", c, obs, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_collision();
        push_idle(1'b1, 1'b0);
        push_txn(16'h1234, 16'h8001, 6, 4);
        push_idle(1'b1, 1'b1);
        push_idle(1'b1, 1'b1);
        for (int c = 0; exp_q.size() > 0; c++) begin
            if (c == 0) begin
                in_valid = 1'b1;
                in_features_flat = {16'h8001, 16'h1234};
            end
            if (c == 1) in_valid = 1'b0;
            if (c == 3) wr_en_mon = 1'b1;
            if (c == 4) wr_en_mon = 1'b0;
            @(negedge clk);
            obs = sample();
            expv = exp_q.pop_front();
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL collision cyc%0d: got %h want %h", c, obs, expv);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        push_idle(1'b1, 1'b1);
        push_txn(16'h0055, 16'h00AA, 3, 0);
        exp_hold = '0;
        repeat (4) push_idle(1'b1, 1'b0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            if (c == 0) begin
                in_valid = 1'b1;
                in_features_flat = {16'h00AA, 16'h0055};
            end
            if (c == 1) in_valid = 1'b0;
            if (c == 3) rst = 1'b1;
            if (c == 4) rst = 1'b0;
            @(negedge clk);
            obs = sample();
            expv = exp_q.pop_front();
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL reset_mid cyc%0d: got %h want %h", c, obs, expv);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef MLP_SEQ_OUT_BACKPRESSURE_EN
    task automatic test_backpressure();
        obs_t o;
        push_idle(1'b1, 1'b0);
        push_txn(16'h0101, 16'h0202, 5, 100);
        for (int k = 6; k <= 10; k++) begin
            o = '0;
            o.val = exp_hold;
            o.ov  = 1'b1;
            o.bsy = 1'b1;
            exp_q.push_back(o);
        end
        push_idle(1'b1, 1'b0);
        for (int c = 0; exp_q.size() > 0; c++) begin
            if (c == 0) begin
                in_valid = 1'b1;
                out_ready = 1'b0;
                in_features_flat = {16'h0202, 16'h0101};
            end
            if (c == 1) in_valid = 1'b0;
            if (c == 10) out_ready = 1'b1;
            @(negedge clk);
            obs = sample();
            expv = exp_q.pop_front();
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL backpressure cyc%0d: got %h want %h", c, obs, expv);
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wr_en_idle();
        test_collision();
        test_reset_mid();
`ifdef MLP_SEQ_OUT_BACKPRESSURE_EN
        test_backpressure();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mlp_hidden_sequencer.md
Name: mlp_hidden_sequencer

Overview:
- Upstream control stage for the hidden-layer compute block.
- Accepts one feature vector per transaction through a valid/ready handshake and prepends the bias term.
- Serially drives input_index, input_value, start, valid and relu_en so the hidden layer computes all neuron outputs.
- Signals out_valid once the layer's outputs_flat register holds the new result.

Parameters:
- N_FEATURES, 2, number of external features; derived localparam N_INPUTS = N_FEATURES+1.
- IN_WIDTH, 16, bit-width of each signed feature and of input_value.
- BIAS_VAL, 256, signed bias input value (1.0 in Q8.8), driven at index 0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset (synchronous, active-high).
- in_valid  in  1  feature vector present.
- in_ready  out  1  sequencer can accept a vector.
- in_features_flat  in  N_FEATURES*IN_WIDTH  feature k at bits [k*IN_WIDTH +: IN_WIDTH], k=0..N_FEATURES-1.
- wr_en_mon  in  1  copy of the hidden layer's weight-memory wr_en.
- input_index  out  clog2(N_INPUTS)  weight-memory read address to the layer.
- input_value  out  IN_WIDTH  signed value to the layer MACs.
- start  out  1  MAC initialise strobe.
- valid  out  1  MAC accumulate strobe.
- relu_en  out  1  ReLU/clip register enable.
- out_valid  out  1  layer outputs_flat holds a fresh result.
- busy  out  1  transaction in progress.
- load_collision  out  1  sticky error flag.

Behaviour:
- Reset: state IDLE; input_index=0, input_value=0, start=valid=relu_en=out_valid=0, load_collision=0. Reset mid-transaction aborts immediately; the partial result is discarded and no out_valid is issued.
- in_ready = (state==IDLE) && !wr_en_mon. busy = (state!=IDLE).
- Acceptance at cycle 0, when in_valid && in_ready:
  - latch in_features_flat into an internal vector reg;
  - element 0 = BIAS_VAL, element k+1 = feature k.
- Weight memory has a 1-cycle registered read, so value and strobes lag the index by one cycle.
- States:
  - IDLE: wait for acceptance, then go to ISSUE.
  - ISSUE: cycles 1..N_INPUTS. input_index = cycle-1; a counter increments each cycle. Leave after index N_INPUTS-1 is issued.
  - Strobe pipeline: one register stage. In cycle c+1 drive input_value = element[c]. Assert start when c==0, valid when c>0. start and valid are never high together.
  - DRAIN: cycle N_INPUTS+1 carries the last valid, then go to RELU.
  - RELU: cycle N_INPUTS+2, relu_en=1 for exactly one cycle.
  - DONE: cycle N_INPUTS+3, out_valid=1 for one cycle, then IDLE.
- Latency: acceptance to out_valid = N_INPUTS+3 cycles (6 for defaults).
- Throughput: next acceptance is possible in the cycle after out_valid, i.e. one vector per N_INPUTS+4 cycles.
- input_value holds its last value when no strobe is active; input_index returns to 0 in IDLE.
- in_valid while busy: ignored, no latch.
- in_features_flat is sampled only at acceptance.
- If wr_en_mon is high in any non-IDLE state:
  - set load_collision (sticky until rst);
  - the transaction continues and out_valid still fires, but the result is undefined.
- Width rule: BIAS_VAL is truncated/sign-preserved to IN_WIDTH. No arithmetic is performed on features.

Optional Feature:
- Macro MLP_SEQ_OUT_BACKPRESSURE_EN.
- When defined:
  - adds input port out_ready (1 bit);
  - DONE holds out_valid=1 until out_ready is high, then goes to IDLE in the following cycle;
  - in_ready stays low throughout DONE;
  - an out_valid && out_ready in the same cycle as in_valid does not accept (accept occurs next cycle).
- When undefined: no out_ready port; out_valid is a single-cycle pulse as above.

Decomposition:
- Shared package mlp_pkg:
  - state encoding constants ST_IDLE, ST_ISSUE, ST_DRAIN, ST_RELU, ST_DONE (3-bit);
  - default IN_WIDTH;
  - Q8.8 ONE constant (256), reused by the output-layer sequencer.
- No sub-module: FSM, index counter and the one-stage strobe pipeline stay in this module.

Test Plan:
- Reset then one transaction with features {0x0100, 0xFF00}, wr_en_mon=0:
  - index 0,1,2 on cycles 1-3;
  - input_value 256, 256, -256 on cycles 2-4;
  - start on cycle 2, valid on cycles 3-4;
  - relu_en on cycle 5, out_valid on cycle 6.
- in_valid held high continuously: second acceptance occurs on cycle 7; in_ready is low on cycles 1-6; the feature change during busy is ignored.
- wr_en_mon=1 while IDLE with in_valid=1: in_ready=0, no acceptance. Drop wr_en_mon: accept on the next cycle.
- wr_en_mon pulsed on cycle 3: load_collision=1 from cycle 4 and stays set; out_valid still on cycle 6.
- rst asserted on cycle 3: all strobes 0 on cycle 4, no out_valid, in_ready=1 after rst deasserts.
- With MLP_SEQ_OUT_BACKPRESSURE_EN and out_ready=0 for 4 cycles: out_valid held from cycle 6 to cycle 10. out_ready=1 on cycle 10 gives IDLE on cycle 11.
